// File: rtl/adder_pkg.sv
// Shared constants and types for the 16-bit carry-lookahead adder slice.
// Imported by the adder top, its cla4 group cell and the testbench.
package adder_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int ADD_GROUP = 4;

    typedef logic [ADD_WIDTH-1:0] word_t;

    // Two's-complement overflow: like-signed operands gave an opposite-signed result.
    function automatic logic signedOverflow(input logic aMsb, input logic bMsb, input logic sMsb);
        return (aMsb == bMsb) && (sMsb != aMsb);
    endfunction

endpackage

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead group: sum bits from internal lookahead carries, plus
// group generate/propagate that never depend on the incoming carry.
module cla4
    import adder_pkg::*;
(
    input  logic [ADD_GROUP-1:0] a,
    input  logic [ADD_GROUP-1:0] b,
    input  logic                 ci,
    output logic [ADD_GROUP-1:0] s,
    output logic                 g,
    output logic                 p
);

    logic [ADD_GROUP-1:0] bitG;
    logic [ADD_GROUP-1:0] bitP;
    logic [ADD_GROUP-1:0] bitC;

    assign bitG = a & b;
    assign bitP = a ^ b;

    // Every internal carry is a flat sum-of-products of ci, so no ripple inside the group.
    always_comb begin
        bitC    = '0;
        bitC[0] = ci;
        bitC[1] = bitG[0] | (bitP[0] & ci);
        bitC[2] = bitG[1] | (bitP[1] & bitG[0]) | (bitP[1] & bitP[0] & ci);
        bitC[3] = bitG[2] | (bitP[2] & bitG[1]) | (bitP[2] & bitP[1] & bitG[0])
                | (bitP[2] & bitP[1] & bitP[0] & ci);
    end

    assign s = bitP ^ bitC;

    assign g = bitG[3]
             | (bitP[3] & bitG[2])
             | (bitP[3] & bitP[2] & bitG[1])
             | (bitP[3] & bitP[2] & bitP[1] & bitG[0]);
    assign p = &bitP;

endmodule

// File: rtl/adder.sv
// Registered WIDTH-bit adder built from cla4 groups with a group-level carry chain;
// produces carry-out, signed overflow, zero flag and a valid strobe one cycle later.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int GROUP = ADD_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    localparam int NGROUPS = WIDTH / GROUP;

    logic [NGROUPS-1:0] grpG;
    logic [NGROUPS-1:0] grpP;
    logic [NGROUPS:0]   grpCarry;

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             outValid_q;

    for (genvar gi = 0; gi < NGROUPS; gi++) begin : gen_group
        cla4 u_cla4 (
            .a  (x[gi*GROUP +: GROUP]),
            .b  (y[gi*GROUP +: GROUP]),
            .ci (grpCarry[gi]),
            .s  (sum_d[gi*GROUP +: GROUP]),
            .g  (grpG[gi]),
            .p  (grpP[gi])
        );
    end

    // Group G/P are independent of the carry-in, so this chain has no combinational loop.
    always_comb begin
        grpCarry    = '0;
        grpCarry[0] = cin;
        for (int i = 0; i < NGROUPS; i++) begin
            grpCarry[i+1] = grpG[i] | (grpP[i] & grpCarry[i]);
        end
    end

    assign cout_d = grpCarry[NGROUPS];
    assign ovf_d  = signedOverflow(x[WIDTH-1], y[WIDTH-1], sum_d[WIDTH-1]);
    assign zero_d = ~|sum_d;

    // Result registers hold through idle cycles; only the valid strobe tracks in_valid every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            outValid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for the registered carry-lookahead adder: directed vectors
// with hand-computed results, valid gating, async reset and a random stream.
module tb_adder;
    import adder_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  inValid;
    word_t xIn;
    word_t yIn;
    logic  cinIn;
    word_t sumOut;
    logic  coutOut;
    logic  ovfOut;
    logic  zeroOut;
    logic  outValid;

    int testsRun;
    int failCount;

    typedef struct {
        string tag;
        word_t x;
        word_t y;
        logic  cin;
        word_t expSum;
        logic  expCout;
        logic  expOvf;
        logic  expZero;
    } vector_t;

    vector_t vectors[$];

    adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .x         (xIn),
        .y         (yIn),
        .cin       (cinIn),
        .sum       (sumOut),
        .cout      (coutOut),
        .ovf       (ovfOut),
        .zero      (zeroOut),
        .out_valid (outValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic applyStimulus(input word_t a, input word_t b, input logic c, input logic v);
        xIn     = a;
        yIn     = b;
        cinIn   = c;
        inValid = v;
        @(negedge clk);
    endtask

    task automatic checkAll(input string tag, input word_t s, input logic co, input logic ov,
                            input logic z, input logic v);
        checkOutput({tag, ".sum"},   32'(sumOut),   32'(s));
        checkOutput({tag, ".cout"},  32'(coutOut),  32'(co));
        checkOutput({tag, ".ovf"},   32'(ovfOut),   32'(ov));
        checkOutput({tag, ".zero"},  32'(zeroOut),  32'(z));
        checkOutput({tag, ".valid"}, 32'(outValid), 32'(v));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        word_t rx;
        word_t ry;
        logic  rc;
        logic [ADD_WIDTH:0] ref17;
        word_t refSum;

        testsRun  = 0;
        failCount = 0;

        vectors.push_back('{"cin1",      16'h0000, 16'h5555, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0});
        vectors.push_back('{"coutA",     16'h9112, 16'hFFFF, 1'b0, 16'h9111, 1'b1, 1'b0, 1'b0});
        vectors.push_back('{"coutB",     16'h9112, 16'hFFFF, 1'b1, 16'h9112, 1'b1, 1'b0, 1'b0});
        vectors.push_back('{"ripple",    16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1});
        vectors.push_back('{"ovfPos",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0});
        vectors.push_back('{"ovfNeg",    16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1});
        vectors.push_back('{"midGroup",  16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0});
        vectors.push_back('{"plain",     16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0});
        vectors.push_back('{"allOnes",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0});

        // Reset held with live random inputs.
        rst_n   = 1'b0;
        inValid = 1'b1;
        xIn     = word_t'($urandom);
        yIn     = word_t'($urandom);
        cinIn   = 1'b1;
        repeat (3) @(negedge clk);
        checkAll("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        applyStimulus(16'h0000, 16'h5555, 1'b0, 1'b1);
        checkAll("first", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1);

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].x, vectors[i].y, vectors[i].cin, 1'b1);
            checkAll(vectors[i].tag, vectors[i].expSum, vectors[i].expCout,
                     vectors[i].expOvf, vectors[i].expZero, 1'b1);
        end

        // Idle cycles with changing inputs: last result (allOnes) must hold.
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
        checkAll("hold1", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b1, 1'b0);
        checkAll("hold2", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);

        // Async reset asserted mid-cycle must clear outputs before any clock edge.
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b1);
        checkAll("preRst", 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRst.clkLow", 32'(clk), 32'd0);
        checkAll("asyncRst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back random stream checked against a 17-bit reference sum.
        for (int n = 0; n < 1000; n++) begin
            rx     = word_t'($urandom);
            ry     = word_t'($urandom);
            rc     = 1'($urandom_range(1));
            ref17  = {1'b0, rx} + {1'b0, ry} + {{ADD_WIDTH{1'b0}}, rc};
            refSum = ref17[ADD_WIDTH-1:0];
            applyStimulus(rx, ry, rc, 1'b1);
            checkAll("rand", refSum, ref17[ADD_WIDTH],
                     (rx[ADD_WIDTH-1] == ry[ADD_WIDTH-1]) && (refSum[ADD_WIDTH-1] != rx[ADD_WIDTH-1]),
                     refSum == 16'h0000, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/adder.md
Name: adder

Overview:
- 16-bit binary adder with carry-in and carry-out; registered outputs, one-cycle latency.
- General-purpose arithmetic leaf used by ALU and address-generation datapaths.
- Internally built from four 4-bit carry-lookahead groups with group-level carry propagation.
- Adds signed overflow and zero flags plus a valid strobe so downstream logic can qualify results.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4.
- GROUP, 4, bits per carry-lookahead group; fixed at 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x/y/cin qualify this cycle.
- x  input  WIDTH  operand A, unsigned or two's complement.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in, added at LSB weight.
- sum  output  WIDTH  registered (x + y + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of MSB, bit WIDTH of full sum.
- ovf  output  1  registered signed overflow.
- zero  output  1  registered, 1 when sum == 0.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Reset (rst_n low, asynchronous assert; deassert sampled on clk): sum=0, cout=0, ovf=0, zero=0, out_valid=0. Reset mid-operation discards any in-flight result.
- Datapath is combinational from x/y/cin; results are captured on the rising clk edge.
  - Latency is exactly 1 cycle.
  - Throughput is 1 operation per cycle.
  - No backpressure.
- Output registers load only when in_valid=1. When in_valid=0, sum/cout/ovf/zero hold their last values and out_valid goes to 0 on the next edge.
- Arithmetic:
  - {cout,sum} = x + y + cin, computed at WIDTH+1 bits.
  - ovf = (x[MSB]==y[MSB]) && (sum[MSB]!=x[MSB]).
  - zero = ~|sum.
- Carry structure:
  - Each 4-bit group produces generate G and propagate P.
  - Group carries: c[i+1] = G[i] | (P[i] & c[i]), with c[0]=cin.
  - cout = c[4].
- Boundary cases:
  - 0xFFFF+0x0000+1 gives sum=0, cout=1, zero=1, ovf=0.
  - 0x7FFF+0x0001+0 gives sum=0x8000, ovf=1, cout=0.
  - 0x8000+0x8000+0 gives sum=0, cout=1, ovf=1, zero=1.
- No X propagation from unused state. All outputs are driven from flops.

Decomposition:
- Shared package adder_pkg:
  - ADD_WIDTH=16 and ADD_GROUP=4 constants.
  - Typedef for WIDTH-bit operand word.
- One sub-module, cla4:
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], g, p.
  - Internal bit-level lookahead.
- Top module instantiates WIDTH/4 cla4 instances and contains the group carry chain, flag logic and output registers.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release rst_n, then drive x=0x0000, y=0x5555, cin=0, in_valid=1 -> one edge later sum=0x5555, cout=0, ovf=0, zero=0, out_valid=1.
- Carry-in, then carry-out:
  - x=0x0000, y=0x5555, cin=1 -> sum=0x5556, cout=0.
  - x=0x9112, y=0xFFFF, cin=0 -> sum=0x9111, cout=1, ovf=0.
  - x=0x9112, y=0xFFFF, cin=1 -> sum=0x9112, cout=1, ovf=0.
- Full-width carry ripple through all groups: x=0xFFFF, y=0x0000, cin=1 -> sum=0x0000, cout=1, zero=1.
- Signed overflow:
  - x=0x7FFF, y=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0.
  - x=0x8000, y=0x8000, cin=0 -> sum=0x0000, ovf=1, cout=1.
- Valid gating and async reset:
  - Drop in_valid for 2 cycles with changing inputs -> sum holds, out_valid=0.
  - Assert rst_n=0 between clock edges -> outputs clear immediately, without waiting for clk.
- Back-to-back random stream of 1000 vectors, one per cycle -> each result matches the 17-bit reference sum delayed by exactly one cycle.
